axi_read_master_port: RTL and testbench

- Master-side read port. One instance per master, placed directly upstream of the fabric read arbiter.
- Accepts AR commands from a master core and converts them into arbiter request/grant signalling. Issues the granted AR onto the fabric, then returns fabric R beats to the master.
- Tracks outstanding transaction IDs and beat counts per ID, and flags protocol errors.

---
 rtl/read_port_pkg.sv | 20 ++
 rtl/axi_read_master_port_tracker.sv | 78 +++++++
 rtl/axi_read_master_port.sv | 140 ++++++++++++++
 tb/tb_axi_read_master_port.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/read_port_pkg.sv
// Shared types and width helpers for the master-side AXI read port.
// AR FSM encoding plus default ID/counter widths.
package read_port_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_ISSUE   = 2'd2,
    S_RELEASE = 2'd3
  } ar_state_e;

  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_TRANS = 2;
  localparam int IDW  = idw_of(DEF_NUM_TRANS);
  localparam int CNTW = IDW + 1;

endpackage

// File: rtl/axi_read_master_port_tracker.sv
// Per-ID outstanding/beat bookkeeping for the read port.
// Flags unexpected, early-last and missing-last beats.
module read_beat_tracker
  import read_port_pkg::*;
#(
  parameter int NUM = 2,
  parameter int LW  = 8,
  parameter int IW  = 1,
  parameter int CW  = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          set_i,
  input  logic [IW-1:0] set_id_i,
  input  logic [LW-1:0] set_len_i,
  input  logic          rhs_i,
  input  logic [IW-1:0] rid_i,
  input  logic          rlast_i,
  output logic [NUM-1:0] pending_o,
  output logic [CW-1:0] outstanding_cnt_o,
  output logic          err_o
);

  logic [NUM-1:0]         pend_q, pend_d;
  logic [NUM-1:0][LW-1:0] cnt_q, cnt_d;
  logic [NUM-1:0][LW-1:0] len_q, len_d;
  logic                   err_q, err_d;

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    err_d  = err_q;
    if (rhs_i) begin
      if (!pend_q[rid_i]) begin
        err_d = 1'b1;
      end else if (rlast_i) begin
        if (cnt_q[rid_i] != len_q[rid_i]) err_d = 1'b1;
        pend_d[rid_i] = 1'b0;
        cnt_d[rid_i]  = '0;
      end else if (cnt_q[rid_i] == len_q[rid_i]) begin
        err_d = 1'b1;
      end else begin
        cnt_d[rid_i] = cnt_q[rid_i] + 1'b1;
      end
    end
    // A new AR on the same ID overrides a concurrent R clear
    if (set_i) begin
      pend_d[set_id_i] = 1'b1;
      len_d[set_id_i]  = set_len_i;
      cnt_d[set_id_i]  = '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pend_q <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    outstanding_cnt_o = '0;
    for (int i = 0; i < NUM; i++)
      outstanding_cnt_o = outstanding_cnt_o + CW'(pend_q[i]);
  end

  assign pending_o = pend_q;
  assign err_o     = err_q;

endmodule

// File: rtl/axi_read_master_port.sv
// Master-side AXI read port: AR arbitration handshake, fabric issue,
// and zero-latency R return with per-ID beat tracking.
module axi_read_master_port
  import read_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUTSTANDING_TRANS = 2,
  parameter int LEN_WIDTH = 8,
  localparam int IW = idw_of(NUM_OUTSTANDING_TRANS),
  localparam int CW = IW + 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  m_arvalid,
  output logic                  m_arready,
  input  logic [ADDR_WIDTH-1:0] m_araddr,
  input  logic [IW-1:0]         m_arid,
  input  logic [LEN_WIDTH-1:0]  m_arlen,
  output logic                  ar_request,
  input  logic                  ar_grant,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [IW-1:0]         ar_id,
  output logic                  f_arvalid,
  input  logic                  f_arready,
  output logic [ADDR_WIDTH-1:0] f_araddr,
  output logic [IW-1:0]         f_arid,
  output logic [LEN_WIDTH-1:0]  f_arlen,
  input  logic                  f_rvalid,
  output logic                  f_rready,
  input  logic [DATA_WIDTH-1:0] f_rdata,
  input  logic [IW-1:0]         f_rid,
  input  logic                  f_rlast,
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [IW-1:0]         m_rid,
  output logic                  m_rlast,
  output logic [CW-1:0]         outstanding_cnt,
  output logic                  busy,
  output logic                  err
);

  ar_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IW-1:0]         id_q, id_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [NUM_OUTSTANDING_TRANS-1:0] pending;
  logic                  set;
  logic                  rhs;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    id_d       = id_q;
    len_d      = len_q;
    m_arready  = 1'b0;
    ar_request = 1'b0;
    f_arvalid  = 1'b0;
    set        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        m_arready = !pending[m_arid];
        if (m_arvalid && m_arready) begin
          addr_d  = m_araddr;
          id_d    = m_arid;
          len_d   = m_arlen;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        ar_request = 1'b1;
        if (ar_grant) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        ar_request = 1'b1;
        f_arvalid  = ar_grant;
        if (f_arvalid && f_arready) begin
          set     = 1'b1;
          state_d = S_RELEASE;
        end else if (!ar_grant) begin
          state_d = S_REQ;
        end
      end
      S_RELEASE: begin
        if (!ar_grant) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
    end
  end

  assign ar_addr  = addr_q;
  assign ar_id    = id_q;
  assign f_araddr = addr_q;
  assign f_arid   = id_q;
  assign f_arlen  = len_q;

  assign m_rvalid = f_rvalid;
  assign f_rready = m_rready;
  assign m_rdata  = f_rdata;
  assign m_rid    = f_rid;
  assign m_rlast  = f_rlast;
  assign rhs      = f_rvalid && m_rready;

  read_beat_tracker #(
    .NUM(NUM_OUTSTANDING_TRANS),
    .LW (LEN_WIDTH),
    .IW (IW),
    .CW (CW)
  ) u_trk (
    .clk              (clk),
    .clr              (clr),
    .set_i            (set),
    .set_id_i         (id_q),
    .set_len_i        (len_q),
    .rhs_i            (rhs),
    .rid_i            (f_rid),
    .rlast_i          (f_rlast),
    .pending_o        (pending),
    .outstanding_cnt_o(outstanding_cnt),
    .err_o            (err)
  );

  assign busy = (state_q != S_IDLE) || (|pending);

endmodule

// File: tb/tb_axi_read_master_port.sv
// Directed self-checking bench for axi_read_master_port.
// Hand-computed expectations checked with immediate assertions.
module tb_axi_read_master_port;

  logic        clk = 1'b0;
  logic        clr;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [0:0]  m_arid;
  logic [7:0]  m_arlen;
  logic        ar_request, ar_grant;
  logic [31:0] ar_addr;
  logic [0:0]  ar_id;
  logic        f_arvalid, f_arready;
  logic [31:0] f_araddr;
  logic [0:0]  f_arid;
  logic [7:0]  f_arlen;
  logic        f_rvalid, f_rready;
  logic [31:0] f_rdata;
  logic [0:0]  f_rid;
  logic        f_rlast;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [0:0]  m_rid;
  logic        m_rlast;
  logic [1:0]  outstanding_cnt;
  logic        busy, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_read_master_port dut (
    .clk(clk), .clr(clr),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .ar_request(ar_request), .ar_grant(ar_grant),
    .ar_addr(ar_addr), .ar_id(ar_id),
    .f_arvalid(f_arvalid), .f_arready(f_arready),
    .f_araddr(f_araddr), .f_arid(f_arid), .f_arlen(f_arlen),
    .f_rvalid(f_rvalid), .f_rready(f_rready),
    .f_rdata(f_rdata), .f_rid(f_rid), .f_rlast(f_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rlast(m_rlast),
    .outstanding_cnt(outstanding_cnt), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_req", ar_request, 0);
    chk("rst_farv", f_arvalid, 0);
    chk("rst_cnt", outstanding_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_arrdy", m_arready, 1);
  endtask

  task automatic do_reset();
    clr = 1'b0;
    ar_grant = 1'b0;
    f_arready = 1'b0;
    f_rvalid = 1'b0;
    m_arvalid = 1'b0;
    m_arid = 1'b0;
    #1;
    chk_reset_outs();
    @(negedge clk);
    clr = 1'b1;
    tick();
  endtask

  // Full AR flow: accept, request, grant after 2 cycles, issue with
  // `stall` cycles of f_arready low, release.
  task automatic do_ar(input logic [31:0] a, input logic id,
                       input logic [7:0] len, input int stall);
    m_arvalid = 1'b1;
    m_araddr = a;
    m_arid = id;
    m_arlen = len;
    #1;
    chk("ar_accept_rdy", m_arready, 1);
    tick();
    m_arvalid = 1'b0;
    m_araddr = 32'hDEAD_BEEF;
    #1;
    chk("req_hi", ar_request, 1);
    chk("req_addr", ar_addr, a);
    chk("req_id", ar_id, id);
    chk("req_farv", f_arvalid, 0);
    tick();
    tick();
    chk("req_wait", ar_request, 1);
    ar_grant = 1'b1;
    tick();
    for (int i = 0; i < stall; i++) begin
      chk("stall_farv", f_arvalid, 1);
      chk("stall_req", ar_request, 1);
      chk("stall_addr", f_araddr, a);
      tick();
    end
    f_arready = 1'b1;
    #1;
    chk("iss_farv", f_arvalid, 1);
    chk("iss_addr", f_araddr, a);
    chk("iss_id", f_arid, id);
    chk("iss_len", f_arlen, len);
    tick();
    f_arready = 1'b0;
    #1;
    chk("rel_req", ar_request, 0);
    chk("rel_farv", f_arvalid, 0);
    ar_grant = 1'b0;
    tick();
  endtask

  task automatic beat(input logic id, input logic last,
                      input logic [31:0] d);
    f_rvalid = 1'b1;
    f_rid = id;
    f_rlast = last;
    f_rdata = d;
    m_rready = 1'b1;
    #1;
    chk("r_valid", m_rvalid, 1);
    chk("r_data", m_rdata, d);
    chk("r_id", m_rid, id);
    chk("r_last", m_rlast, last);
    chk("r_ready", f_rready, 1);
    tick();
    f_rvalid = 1'b0;
    f_rlast = 1'b0;
  endtask

  initial begin
    clr = 1'b0;
    m_araddr = '0; m_arlen = '0;
    f_rdata = '0; f_rid = '0; f_rlast = 1'b0;
    m_rready = 1'b1;
    do_reset();

    // Single AR id0 len3
    do_ar(32'h0001_0040, 1'b0, 8'd3, 0);
    chk("t1_cnt", outstanding_cnt, 1);
    chk("t1_busy", busy, 1);
    m_arvalid = 1'b1;
    m_arid = 1'b0;
    #1;
    chk("t2_blk0", m_arready, 0);
    m_arvalid = 1'b0;

    // id1 accepted while id0 pending; also 5-cycle f_arready stall
    do_ar(32'h0002_0080, 1'b1, 8'd1, 5);
    chk("t2_cnt2", outstanding_cnt, 2);

    m_arid = 1'b0;
    beat(1'b0, 1'b0, 32'hA0);
    beat(1'b0, 1'b0, 32'hA1);
    beat(1'b0, 1'b0, 32'hA2);
    chk("t2_still_blk", m_arready, 0);
    beat(1'b0, 1'b1, 32'hA3);
    chk("t1_cnt_after", outstanding_cnt, 1);
    chk("t2_unblk", m_arready, 1);
    chk("t1_err", err, 0);
    beat(1'b1, 1'b0, 32'hB0);
    beat(1'b1, 1'b1, 32'hB1);
    chk("t3_cnt0", outstanding_cnt, 0);
    chk("t3_busy0", busy, 0);
    chk("t3_err", err, 0);

    // Early last
    do_ar(32'h0000_1000, 1'b0, 8'd1, 0);
    beat(1'b0, 1'b1, 32'hC0);
    chk("t4_err", err, 1);
    chk("t4_cnt", outstanding_cnt, 0);
    tick();
    chk("t4_sticky", err, 1);
    do_reset();

    // Missing last
    do_ar(32'h0000_2000, 1'b1, 8'd1, 0);
    beat(1'b1, 1'b0, 32'hD0);
    chk("t4b_noerr", err, 0);
    beat(1'b1, 1'b0, 32'hD1);
    chk("t4b_err", err, 1);
    chk("t4b_cnt", outstanding_cnt, 1);
    beat(1'b1, 1'b1, 32'hD2);
    chk("t4b_clr", outstanding_cnt, 0);
    do_reset();

    // Beat for an ID that is not pending
    beat(1'b1, 1'b0, 32'hE0);
    chk("t5_err", err, 1);
    chk("t5_cnt", outstanding_cnt, 0);
    do_reset();

    // m_rready low blocks the handshake and the count
    do_ar(32'h0000_3000, 1'b0, 8'd3, 0);
    f_rvalid = 1'b1;
    f_rid = 1'b0;
    f_rlast = 1'b0;
    m_rready = 1'b0;
    #1;
    chk("t5_frdy", f_rready, 0);
    chk("t5_mrv", m_rvalid, 1);
    tick();
    f_rvalid = 1'b0;
    beat(1'b0, 1'b0, 32'hF0);
    beat(1'b0, 1'b0, 32'hF1);
    beat(1'b0, 1'b0, 32'hF2);
    beat(1'b0, 1'b1, 32'hF3);
    chk("t5_noinc_err", err, 0);
    chk("t5_noinc_cnt", outstanding_cnt, 0);

    // Reset while in ISSUE with id0 pending
    do_ar(32'h0000_4000, 1'b0, 8'd2, 0);
    m_arvalid = 1'b1;
    m_arid = 1'b1;
    m_araddr = 32'h0000_5000;
    tick();
    m_arvalid = 1'b0;
    ar_grant = 1'b1;
    tick();
    chk("t6_issue", f_arvalid, 1);
    clr = 1'b0;
    #1;
    chk_reset_outs();
    ar_grant = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    tick();
    beat(1'b0, 1'b0, 32'h77);
    chk("t6_err", err, 1);
    chk("t6_cnt", outstanding_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
